fetch_queue_nw: RTL

- Parametrised N-wide successor of the 2-wide front-end instruction queue.
- Holds a preloaded program in a local instruction store and fetches up to FW words per cycle into an in-block circular buffer tagged with PC.
- Presents up to DW oldest entries to dispatch and tracks the architectural commit PC from up to CW commits per cycle.
- Supports flush, resume and a front-end redirect. Decode sits downstream of out_instr.

---
 rtl/fetch_queue_nw.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fetch_queue_nw.sv
// Purpose : N-wide front-end fetch queue. A preloaded instruction store feeds up to FW
//           words per cycle into a PC-tagged circular buffer; up to DW oldest entries
//           are shown to dispatch, and the architectural commit PC advances by up to
//           CW commits per cycle.
// Latency : a fetched entry appears on out_* the cycle after it is written (no bypass).
// Backpressure: fetch halts when the buffer is full (free space taken from the registered
//           count, before this cycle's pops), when stall/flush/resume/redirect is high,
//           or when fetch_pc has reached load_pc.
// Ports   : clk/rst_n; program load (wr_en, wr_instr, load_full); dispatch (out_valid,
//           out_instr, out_pc, rd_en, occupancy); control (stall, redirect_valid/pc,
//           flush, resume/resume_pc); commit (cmt_valid, cmt_pc_o, completed).
module fetch_queue_nw #(
    parameter int SIZE  = 256,
    parameter int DEPTH = 8,
    parameter int FW    = 2,
    parameter int DW    = 2,
    parameter int CW    = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [31:0]                wr_instr,
    output logic                       load_full,
    output logic [DW-1:0]              out_valid,
    output logic [DW-1:0][31:0]        out_instr,
    output logic [DW-1:0][31:0]        out_pc,
    input  logic [DW-1:0]              rd_en,
    output logic [$clog2(DEPTH):0]     occupancy,
    input  logic                       stall,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    input  logic                       flush,
    input  logic [CW-1:0]              cmt_valid,
    input  logic                       resume,
    input  logic [31:0]                resume_pc,
    output logic [31:0]                cmt_pc_o,
    output logic                       completed
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CNTW = PW + 1;
    localparam int AW   = $clog2(SIZE);

    logic [31:0]     mem [SIZE];

    logic [31:0]     load_pc_q,  load_pc_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     cmt_pc_q,   cmt_pc_d;
    logic [PW-1:0]   head_q,     head_d;
    logic [PW-1:0]   tail_q,     tail_d;
    logic [CNTW-1:0] count_q,    count_d;
    logic [31:0]     buf_instr_q [DEPTH];
    logic [31:0]     buf_instr_d [DEPTH];
    logic [31:0]     buf_pc_q    [DEPTH];
    logic [31:0]     buf_pc_d    [DEPTH];

    logic [31:0]     fetch_k;
    logic [31:0]     pop_n;
    logic [31:0]     cmt_n;
    logic [31:0]     avail;
    logic [31:0]     free_n;
    logic [31:0]     word_pc;
    logic [PW-1:0]   widx;
    logic            load_ok;

    assign load_full = (load_pc_q == 32'(4 * SIZE));
    assign load_ok   = wr_en && !load_full;
    assign completed = (load_pc_q == cmt_pc_q);
    assign cmt_pc_o  = cmt_pc_q;
    assign occupancy = count_q;

    // Program store: written only by the loader, never reset.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_pc_q[AW+1:2]] <= wr_instr;
        end
    end

    always_comb begin
        load_pc_d   = load_ok ? load_pc_q + 32'd4 : load_pc_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        word_pc     = '0;
        widx        = '0;

        // Words still loadable beyond fetch_pc; none once fetch_pc has caught up.
        avail  = (fetch_pc_q >= load_pc_q) ? 32'd0 : ((load_pc_q - fetch_pc_q) >> 2);
        free_n = 32'(DEPTH) - 32'(count_q);
        fetch_k = 32'(FW);
        if (free_n < fetch_k) fetch_k = free_n;
        if (avail  < fetch_k) fetch_k = avail;
        if (stall || flush || resume || redirect_valid) fetch_k = '0;

        pop_n = '0;
        for (int i = 0; i < DW; i++) begin
            pop_n = pop_n + 32'(rd_en[i]);
        end
        cmt_n = '0;
        for (int i = 0; i < CW; i++) begin
            cmt_n = cmt_n + 32'(cmt_valid[i]);
        end

        for (int j = 0; j < FW; j++) begin
            if (32'(j) < fetch_k) begin
                word_pc              = fetch_pc_q + 32'(4 * j);
                widx                 = tail_q + PW'(j);
                buf_instr_d[widx]    = mem[word_pc[AW+1:2]];
                buf_pc_d[widx]       = word_pc;
            end
        end

        cmt_pc_d = resume ? resume_pc : cmt_pc_q + (cmt_n << 2);

        // Flush restarts from the commit PC including this cycle's commits.
        if (resume)              fetch_pc_d = resume_pc;
        else if (flush)          fetch_pc_d = cmt_pc_d;
        else if (redirect_valid) fetch_pc_d = redirect_pc;
        else                     fetch_pc_d = fetch_pc_q + (fetch_k << 2);

        if (flush || resume) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(pop_n);
            tail_d  = tail_q + PW'(fetch_k);
            count_d = CNTW'(32'(count_q) + fetch_k - pop_n);
        end
    end

    always_comb begin
        for (int i = 0; i < DW; i++) begin
            out_valid[i] = 32'(count_q) > 32'(i);
            out_instr[i] = buf_instr_q[head_q + PW'(i)];
            out_pc[i]    = buf_pc_q[head_q + PW'(i)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_pc_q  <= '0;
            fetch_pc_q <= '0;
            cmt_pc_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_instr_q[i] <= '0;
                buf_pc_q[i]    <= '0;
            end
        end else begin
            load_pc_q   <= load_pc_d;
            fetch_pc_q  <= fetch_pc_d;
            cmt_pc_q    <= cmt_pc_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
        end
    end
endmodule
